// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU/PC+4 results in one cycle and waits for load data.
// Optional build macro WB_FWD_EN exposes the register-file write as a bypass port.
module writeback_stage #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [1:0]        in_wb_sel,
  input  logic [2:0]        in_funct3,
  input  logic [1:0]        in_addr_lo,
  input  logic [XLEN-1:0]   in_alu,
  input  logic [XLEN-1:0]   in_pc4,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [XLEN-1:0]   wd3,
  output logic              busy,
  output logic [31:0]       wr_count
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [XLEN-1:0]   fwd_data
`endif
);

  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_LOAD = 2'b10;

  typedef enum logic {IDLE, WAIT_RSP} state_e;

  state_e              state_q, state_d;
  logic                we3_q, we3_d;
  logic [ADDR_W-1:0]   wa3_q, wa3_d;
  logic [XLEN-1:0]     wd3_q, wd3_d;
  logic [31:0]         wr_count_q;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          addr_lo_q, addr_lo_d;

  // Select and extend the addressed byte/half of a load response.
  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3,
                                               input logic [1:0] lo,
                                               input logic [XLEN-1:0] data);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = 8'(data >> {lo, 3'b000});
    h = 16'(data >> {lo[1], 4'b0000});
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = data;
    endcase
    return r;
  endfunction

  // Next-state and write-port decode.
  always_comb begin
    state_d   = state_q;
    we3_d     = 1'b0;
    wa3_d     = wa3_q;
    wd3_d     = wd3_q;
    rd_d      = rd_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_wb_sel == WB_LOAD) begin
            rd_d      = in_rd;
            funct3_d  = in_funct3;
            addr_lo_d = in_addr_lo;
            state_d   = WAIT_RSP;
          end else if (in_wb_sel != WB_NONE && in_rd != '0) begin
            we3_d = 1'b1;
            wa3_d = in_rd;
            wd3_d = (in_wb_sel == WB_ALU) ? in_alu : in_pc4;
          end
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
          if (rd_q != '0) begin
            we3_d = 1'b1;
            wa3_d = rd_q;
            wd3_d = load_ext(funct3_q, addr_lo_q, mem_rsp_data);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we3_q      <= 1'b0;
      wa3_q      <= '0;
      wd3_q      <= '0;
      wr_count_q <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
    end else begin
      state_q    <= state_d;
      we3_q      <= we3_d;
      wa3_q      <= wa3_d;
      wd3_q      <= wd3_d;
      wr_count_q <= wr_count_q + 32'(we3_q);
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == WAIT_RSP);
  assign we3      = we3_q;
  assign wa3      = wa3_q;
  assign wd3      = wd3_q;
  assign wr_count = wr_count_q;

`ifdef WB_FWD_EN
  // Same-cycle bypass of the register-file write for decode.
  assign fwd_valid = we3_q;
  assign fwd_addr  = wa3_q;
  assign fwd_data  = wd3_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a transaction-level reference model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu;
  logic [31:0] in_pc4;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        busy;
  logic [31:0] wr_count;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_stage #(.ADDR_W(5), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alu(in_alu), .in_pc4(in_pc4),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .we3(we3), .wa3(wa3), .wd3(wd3), .busy(busy), .wr_count(wr_count)
`ifdef WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
  );

  // Load result from the access size and sign rules, using plain shift/mask math.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] d);
    int          sh;
    logic [31:0] mask;
    logic [31:0] v;
    if (f3[1]) return d;
    sh   = f3[0] ? 8 * int'(lo & 2'b10) : 8 * int'(lo);
    mask = f3[0] ? 32'h0000_FFFF : 32'h0000_00FF;
    v    = (d >> sh) & mask;
    if (!f3[2] && ((v & ~(mask >> 1)) != 0)) v = v | ~mask;
    return v;
  endfunction

  // Reference model: one pending-load flag plus the write each accepted op must produce.
  logic        m_pend, m_we;
  logic [4:0]  m_wa, m_rd;
  logic [31:0] m_wd, m_cnt;
  logic [2:0]  m_f3;
  logic [1:0]  m_lo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0; m_we <= 1'b0; m_wa <= '0; m_wd <= '0; m_cnt <= '0;
      m_rd <= '0; m_f3 <= '0; m_lo <= '0;
    end else begin
      m_cnt <= m_cnt + (m_we ? 32'd1 : 32'd0);
      m_we  <= 1'b0;
      if (m_pend) begin
        if (mem_rsp_valid) begin
          m_pend <= 1'b0;
          if (m_rd != 0) begin
            m_we <= 1'b1; m_wa <= m_rd; m_wd <= exp_load(m_f3, m_lo, mem_rsp_data);
          end
        end
      end else if (in_valid) begin
        if (in_wb_sel == 2'b10) begin
          m_pend <= 1'b1; m_rd <= in_rd; m_f3 <= in_funct3; m_lo <= in_addr_lo;
        end else if (in_wb_sel != 2'b00 && in_rd != 0) begin
          m_we <= 1'b1; m_wa <= in_rd; m_wd <= (in_wb_sel == 2'b01) ? in_alu : in_pc4;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output against the model.
  task automatic cyc();
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(!m_pend));
    chk("busy",     32'(busy),     32'(m_pend));
    chk("we3",      32'(we3),      32'(m_we));
    chk("wa3",      32'(wa3),      32'(m_wa));
    chk("wd3",      wd3,           m_wd);
    chk("wr_count", wr_count,      m_cnt);
`ifdef WB_FWD_EN
    chk("fwd_valid", 32'(fwd_valid), 32'(m_we));
    chk("fwd_addr",  32'(fwd_addr),  32'(m_wa));
    chk("fwd_data",  fwd_data,       m_wd);
`endif
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic op(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] val);
    in_valid = 1'b1; in_wb_sel = sel; in_rd = rd; in_alu = val; in_pc4 = ~val;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                      input logic [31:0] data, input int waits, input logic rsp_in_xfer,
                      input logic [31:0] exp_wd);
    in_valid = 1'b1; in_wb_sel = 2'b10; in_rd = rd; in_funct3 = f3; in_addr_lo = lo;
    mem_rsp_valid = rsp_in_xfer; mem_rsp_data = data;
    cyc();
    in_valid = 1'b0; mem_rsp_valid = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    repeat (waits) begin
      cyc();
      chk("load_wait_ready", 32'(in_ready), 32'd0);
    end
    mem_rsp_valid = 1'b1;
    cyc();
    mem_rsp_valid = 1'b0;
    chk("load_ready_in_write", 32'(in_ready), 32'd1);
    chk("load_we3", 32'(we3), (rd != 0) ? 32'd1 : 32'd0);
    if (rd != 0) chk("load_wd3", wd3, exp_wd);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_rd = '0; in_wb_sel = '0; in_funct3 = '0;
    in_addr_lo = '0; in_alu = '0; in_pc4 = '0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    #2 rst_n = 1'b0;
    cyc(); cyc();
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_count", wr_count, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    cyc();

    // Three back-to-back ALU writes.
    in_valid = 1'b1; in_wb_sel = 2'b01; in_rd = 5'd5; in_alu = 32'h1234_5678;
    cyc(); chk("alu_we3_c1", 32'(we3), 32'd1);
    cyc(); chk("alu_we3_c2", 32'(we3), 32'd1);
    cyc(); chk("alu_we3_c3", 32'(we3), 32'd1);
    idle(2);
    chk("alu_wa3", 32'(wa3), 32'd5);
    chk("alu_wd3_hold", wd3, 32'h1234_5678);
    chk("alu_count", wr_count, 32'd3);

    // Byte, half and word loads; one has a stray response in the transfer cycle.
    load(5'd9, 3'b000, 2'd3, 32'h80FF_0000, 4, 1'b1, 32'hFFFF_FF80);
    idle(1);
    load(5'd9, 3'b100, 2'd3, 32'h80FF_0000, 4, 1'b0, 32'h0000_0080);
    load(5'd10, 3'b001, 2'd2, 32'h8001_7FFF, 1, 1'b0, 32'hFFFF_8001);
    load(5'd11, 3'b101, 2'd3, 32'h8001_7FFF, 0, 1'b0, 32'h0000_8001);
    load(5'd12, 3'b010, 2'd2, 32'h8001_7FFF, 2, 1'b0, 32'h8001_7FFF);
    load(5'd13, 3'b000, 2'd1, 32'h0000_7F00, 0, 1'b0, 32'h0000_007F);
    idle(2);
    chk("loads_count", wr_count, 32'd9);

    // Load to x0 consumes the response silently; ALU op accepted right after.
    load(5'd0, 3'b010, 2'd0, 32'hDEAD_BEEF, 2, 1'b0, 32'h0);
    op(2'b01, 5'd6, 32'hCAFE_0001);
    chk("after_x0_we3", 32'(we3), 32'd1);
    op(2'b11, 5'd31, 32'h0000_1000);
    chk("pc4_wd3", wd3, 32'hFFFF_EFFF);
    op(2'b00, 5'd8, 32'h1111_1111);
    op(2'b01, 5'd0, 32'h2222_2222);
    idle(2);
    chk("misc_count", wr_count, 32'd11);
    chk("misc_wa3_hold", 32'(wa3), 32'd31);

`ifdef WB_FWD_EN
    op(2'b01, 5'd7, 32'h0BAD_F00D);
    chk("fwd_valid_lit", 32'(fwd_valid), 32'd1);
    chk("fwd_addr_lit", 32'(fwd_addr), 32'd7);
    chk("fwd_data_lit", fwd_data, 32'h0BAD_F00D);
    idle(1);
`endif

    // Reset in a write cycle cancels it.
    op(2'b01, 5'd3, 32'h3333_3333);
    chk("pre_rst_we3", 32'(we3), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_write_we3", 32'(we3), 32'd0);
    chk("rst_write_count", wr_count, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Reset while waiting drops the load; a late response is ignored.
    in_valid = 1'b1; in_wb_sel = 2'b10; in_rd = 5'd4; in_funct3 = 3'b010;
    cyc();
    in_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rst_wait_busy", 32'(busy), 32'd0);
    chk("rst_wait_ready", 32'(in_ready), 32'd1);
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_5555;
    cyc();
    mem_rsp_valid = 1'b0;
    chk("late_rsp_we3", 32'(we3), 32'd0);
    idle(2);
    chk("late_rsp_count", wr_count, 32'd0);
    chk("late_rsp_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL take parameter ADDR_W, default 5: register address width.
REQ-002 SHALL take parameter XLEN, default 32: data width.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  upstream (MEM) instruction valid.
REQ-006 SHALL have port in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
REQ-007 SHALL have port in_rd  in  ADDR_W  destination register.
REQ-008 SHALL have port in_wb_sel  in  2  00 none, 01 ALU, 10 load, 11 PC+4.
REQ-009 SHALL have port in_funct3  in  3  load type.
REQ-010 SHALL have ports in_addr_lo  in  2, in_alu  in  XLEN, in_pc4  in  XLEN: load address bits [1:0], ALU result, PC+4.
REQ-011 SHALL have ports mem_rsp_valid  in  1 and mem_rsp_data  in  XLEN: data-memory load response.
REQ-012 SHALL have ports we3  out  1, wa3  out  ADDR_W, wd3  out  XLEN: register-file write port.
REQ-013 SHALL have port busy  out  1  high in WAIT_RSP.
REQ-014 SHALL have port wr_count  out  32  count of register writes issued.

Function
REQ-015 SHALL implement states IDLE and WAIT_RSP; in_ready = 1 in IDLE, 0 in WAIT_RSP.
REQ-016 On transfer with wb_sel 01/11 and in_rd != 0, SHALL assert we3 the next cycle for exactly one cycle: wa3 = in_rd, wd3 = in_alu / in_pc4; state stays IDLE (one write per cycle sustained).
REQ-017 On transfer with wb_sel 00, or in_rd == 0 and wb_sel != 10, SHALL consume with no write.
REQ-018 On transfer with wb_sel 10, SHALL latch rd, funct3, addr_lo and go to WAIT_RSP.
REQ-019 In WAIT_RSP on mem_rsp_valid, SHALL assert we3 the next cycle with the extended data and return to IDLE; in_ready is 1 in that write cycle.
REQ-020 Load to x0 SHALL still wait for and consume its response but SHALL NOT assert we3.
REQ-021 mem_rsp_valid sampled in IDLE, including the transfer cycle, SHALL be ignored.
REQ-022 Extension: 000 LB sign-extend byte at data[8*addr_lo+7 : 8*addr_lo]; 100 LBU zero-extend same byte; 001 LH sign-extend half at data[16*addr_lo[1]+15 : 16*addr_lo[1]]; 101 LHU zero-extend; 010, 011, 110, 111 full word; addr_lo[0] ignored for halves; no misalignment trap.
REQ-023 wa3/wd3 SHALL hold last written values while we3 = 0.
REQ-024 wr_count SHALL increment by 1 each cycle we3 = 1, wrapping 0xFFFFFFFF -> 0.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, we3 = 0, wa3 = 0, wd3 = 0, wr_count = 0, busy = 0, latched fields 0.
REQ-026 Reset in WAIT_RSP SHALL drop the pending load; a later response arrives in IDLE and is ignored (REQ-021).
REQ-027 Reset in a write cycle SHALL cancel that write.

Configuration
REQ-028 Macro WB_FWD_EN SHALL add outputs fwd_valid (1), fwd_addr (ADDR_W), fwd_data (XLEN).
REQ-029 With WB_FWD_EN, these SHALL combinationally equal we3, wa3, wd3 so decode can bypass the same-cycle write; reset value 0.
REQ-030 Without WB_FWD_EN, these ports SHALL be absent; all other behaviour identical.

Verification
REQ-031 ALU, rd=5, in_alu=0x1234_5678, transfers in cycles 0,1,2 -> we3 in cycles 1,2,3; wa3=5; wd3=0x12345678; wr_count=3.
REQ-032 LB, addr_lo=3, response 0x80FF_0000 after 4 wait cycles -> in_ready 0 throughout; then one cycle we3, wd3=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-033 LH addr_lo=2, data 0x8001_7FFF -> 0xFFFF_8001; LHU -> 0x0000_8001; LW -> 0x8001_7FFF.
REQ-034 Load rd=0 with response -> no we3; wr_count unchanged; next ALU op accepted in response-plus-one cycle.
REQ-035 rst_n low in WAIT_RSP, response 2 cycles after release -> no we3, in_ready=1, wr_count=0.
REQ-036 With WB_FWD_EN, ALU write rd=7 -> fwd_valid=1, fwd_addr=7, fwd_data=wd3 in the same cycle as we3.
